// File: rtl/vga_scan_encoder.sv
// -----------------------------------------------------------------------------
// vga_scan_encoder
//   Generates 640x480@60 VGA raster timing from the 100 MHz system clock and
//   classifies every pixel into a 3-bit display code for the colour lookup.
//   The lookup's 12-bit colour comes back combinationally. It is blanked
//   outside the active area and registered onto the VGA pins together with
//   the syncs.
//
//   Pipeline (all stages advance on pix_en only):
//     stage 0 : h/v counters, frame counter, per-frame box latch
//     stage 1 : active / hs / vs flags and displayCode
//     stage 2 : RGB + hsync/vsync pin registers
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   box_x/box_y  in   box top-left corner, sampled once per frame
//   displayCode  out  per-pixel code: 000 blank, 001 field, 010 box, 011 border
//   colorIn      in   {R,G,B} 4 bits each, combinational from displayCode
//   vga_r/g/b    out  registered colour, zero outside the active area
//   hsync/vsync  out  registered, active-low syncs
//   frame_start  out  one-clk pulse as the counters step to (0,0)
//   frame_count  out  frames since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
module vga_scan_encoder #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int BORDER   = 8,
    parameter int BOX_SIZE = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  box_x,
    input  logic [9:0]  box_y,
    output logic [2:0]  displayCode,
    input  logic [11:0] colorIn,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // Box edges are compared in 11 bits so box_x + BOX_SIZE never wraps;
    // a box hanging off the screen is simply clipped.
    localparam int CW      = 11;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);

    localparam logic [CW-1:0] H_ACT_C   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_LO = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_HI = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_LO = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_HI = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] BRD_C     = CW'(BORDER);
    localparam logic [CW-1:0] H_BRD_HI  = CW'(H_ACTIVE - BORDER);
    localparam logic [CW-1:0] V_BRD_HI  = CW'(V_ACTIVE - BORDER);
    localparam logic [CW-1:0] BOX_C     = CW'(BOX_SIZE);

    localparam logic [2:0] CODE_BLANK  = 3'b000;
    localparam logic [2:0] CODE_FIELD  = 3'b001;
    localparam logic [2:0] CODE_BOX    = 3'b010;
    localparam logic [2:0] CODE_BORDER = 3'b011;

    // ---------------------------------------------------------------- state
    logic [DW-1:0] div_q,      div_d;
    logic [HW-1:0] h_cnt_q,    h_cnt_d;
    logic [VW-1:0] v_cnt_q,    v_cnt_d;
    logic [15:0]   frm_cnt_q,  frm_cnt_d;
    logic          fstart_q,   fstart_d;
    logic [9:0]    box_x_q,    box_x_d;
    logic [9:0]    box_y_q,    box_y_d;

    logic          act1_q,     act1_d;
    logic          hs1_q,      hs1_d;
    logic          vs1_q,      vs1_d;
    logic [2:0]    code_q,     code_d;

    logic [11:0]   rgb_q,      rgb_d;
    logic          hsync_q,    hsync_d;
    logic          vsync_q,    vsync_d;

    logic          pix_en;
    logic          end_of_line;
    logic          end_of_frame;

    logic [CW-1:0] hx, vx;
    logic [CW-1:0] box_x_end, box_y_end;
    logic          border_c, in_box_c;

    assign pix_en       = (div_q == DIV_LAST);
    assign end_of_line  = (h_cnt_q == H_LAST);
    assign end_of_frame = end_of_line && (v_cnt_q == V_LAST);

    // ------------------------------------------------- stage 0: counters
    always_comb begin
        div_d     = pix_en ? '0 : div_q + DW'(1);
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        frm_cnt_d = frm_cnt_q;
        box_x_d   = box_x_q;
        box_y_d   = box_y_q;
        // Registered so the pulse lands in the same clk the counters show (0,0).
        fstart_d  = pix_en && end_of_frame;

        if (pix_en) begin
            h_cnt_d = end_of_line ? '0 : h_cnt_q + HW'(1);
            if (end_of_line) begin
                v_cnt_d = end_of_frame ? '0 : v_cnt_q + VW'(1);
            end
            // Box is frozen for a whole frame so it never tears mid-scan.
            if (end_of_frame) begin
                frm_cnt_d = frm_cnt_q + 16'd1;
                box_x_d   = box_x;
                box_y_d   = box_y;
            end
        end
    end

    // ------------------------------------------- stage 1: classification
    assign hx        = CW'(h_cnt_q);
    assign vx        = CW'(v_cnt_q);
    assign box_x_end = {1'b0, box_x_q} + BOX_C;
    assign box_y_end = {1'b0, box_y_q} + BOX_C;

    assign border_c  = (hx < BRD_C) || (hx >= H_BRD_HI) ||
                       (vx < BRD_C) || (vx >= V_BRD_HI);
    assign in_box_c  = (hx >= {1'b0, box_x_q}) && (hx < box_x_end) &&
                       (vx >= {1'b0, box_y_q}) && (vx < box_y_end);

    always_comb begin
        act1_d = (hx < H_ACT_C) && (vx < V_ACT_C);
        hs1_d  = !((hx >= H_SYNC_LO) && (hx < H_SYNC_HI));
        vs1_d  = !((vx >= V_SYNC_LO) && (vx < V_SYNC_HI));

        // Priority: blanking, then border, then box, then playfield.
        code_d = CODE_FIELD;
        if (!act1_d) begin
            code_d = CODE_BLANK;
        end else if (border_c) begin
            code_d = CODE_BORDER;
        end else if (in_box_c) begin
            code_d = CODE_BOX;
        end
    end

    // ------------------------------------------------ stage 2: pin drive
    // colorIn already corresponds to code_q, so act1_q is the matching blank.
    always_comb begin
        rgb_d   = act1_q ? colorIn : 12'h000;
        hsync_d = hs1_q;
        vsync_d = vs1_q;
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            frm_cnt_q <= '0;
            fstart_q  <= 1'b0;
            box_x_q   <= '0;
            box_y_q   <= '0;
        end else begin
            div_q     <= div_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            frm_cnt_q <= frm_cnt_d;
            fstart_q  <= fstart_d;
            box_x_q   <= box_x_d;
            box_y_q   <= box_y_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act1_q  <= 1'b0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            code_q  <= CODE_BLANK;
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else if (pix_en) begin
            act1_q  <= act1_d;
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
            code_q  <= code_d;
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    // -------------------------------------------------------------- outputs
    assign displayCode = code_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fstart_q;
    assign frame_count = frm_cnt_q;

endmodule

// File: tb/tb_vga_scan_encoder.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_encoder
//   Runs the encoder with a shrunken raster so several frames fit in a short
//   run. A reference model derives every expected output from the number of
//   clocks since reset release: pixel index = clocks / CLK_DIV, stage 1 shows
//   pixel (idx-1) and the pins show pixel (idx-2). The box used for a pixel
//   is whatever was on box_x/box_y at the edge that started its frame.
// -----------------------------------------------------------------------------
module tb_vga_scan_encoder;

    localparam int CLK_DIV = 4;
    localparam int HA = 40, HFP = 2, HS = 4, HBP = 2;
    localparam int VA = 24, VFP = 2, VS = 2, VBP = 2;
    localparam int BORDER = 2, BOX = 8;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int TOT = HT * VT;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  box_x, box_y;
    logic [2:0]  displayCode;
    logic [11:0] colorIn;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, frame_start;
    logic [15:0] frame_count;

    logic [11:0] lut [8];
    assign colorIn = lut[displayCode];

    always #5 clk = ~clk;

    vga_scan_encoder #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .BORDER(BORDER), .BOX_SIZE(BOX)
    ) dut (
        .clk(clk), .reset(reset), .box_x(box_x), .box_y(box_y),
        .displayCode(displayCode), .colorIn(colorIn),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start), .frame_count(frame_count)
    );

    int nchk = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    // ------------------------------------------------------ reference model
    int n;            // clocks since reset release
    int fb_x [64];    // box in force for each frame since release
    int fb_y [64];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n       <= 0;
            fb_x[0] <= 0;
            fb_y[0] <= 0;
        end else begin
            n <= n + 1;
            if (((n + 1) % CLK_DIV) == 0 && (((n + 1) / CLK_DIV) % TOT) == 0 &&
                ((n + 1) / CLK_DIV / TOT) < 64) begin
                fb_x[(n + 1) / CLK_DIV / TOT] <= int'(box_x);
                fb_y[(n + 1) / CLK_DIV / TOT] <= int'(box_y);
            end
        end
    end

    function automatic int code_at(input int p);
        int f, w, h, v, bx, by;
        f  = (p / TOT > 63) ? 63 : p / TOT;
        w  = p % TOT;
        h  = w % HT;
        v  = w / HT;
        bx = fb_x[f];
        by = fb_y[f];
        if (!(h < HA && v < VA)) return 0;
        if (h < BORDER || h >= HA - BORDER || v < BORDER || v >= VA - BORDER) return 3;
        if (h >= bx && h < bx + BOX && v >= by && v < by + BOX) return 2;
        return 1;
    endfunction

    function automatic int act_at(input int p);
        return (((p % TOT) % HT) < HA && ((p % TOT) / HT) < VA) ? 1 : 0;
    endfunction

    function automatic int hs_at(input int p);
        int h;
        h = (p % TOT) % HT;
        return (h >= HA + HFP && h < HA + HFP + HS) ? 0 : 1;
    endfunction

    function automatic int vs_at(input int p);
        int v;
        v = (p % TOT) / HT;
        return (v >= VA + VFP && v < VA + VFP + VS) ? 0 : 1;
    endfunction

    // --------------------------------------------------------------- checks
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (clk %0d since release, t=%0t)",
                     tag, got, exp, n, $time);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_code"},  32'(displayCode), 32'd0);
        chk({tag, "_rgb"},   32'({vga_r, vga_g, vga_b}), 32'd0);
        chk({tag, "_hsync"}, 32'(hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vsync), 32'd1);
        chk({tag, "_fstart"}, 32'(frame_start), 32'd0);
        chk({tag, "_fcount"}, 32'(frame_count), 32'd0);
    endtask

    always @(negedge clk) begin : chker
        int e;
        logic [11:0] xrgb;
        if (chk_en) begin
            if (reset) begin
                chk_rst("rst");
            end else begin
                e = n / CLK_DIV;
                chk("code",  32'(displayCode), (e >= 1) ? code_at(e - 1) : 0);
                chk("hsync", 32'(hsync), (e >= 2) ? hs_at(e - 2) : 1);
                chk("vsync", 32'(vsync), (e >= 2) ? vs_at(e - 2) : 1);
                xrgb = (e >= 2 && act_at(e - 2) == 1) ? lut[code_at(e - 2)] : 12'h000;
                chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(xrgb));
                chk("fstart", 32'(frame_start),
                    (n > 0 && (n % CLK_DIV) == 0 && (e % TOT) == 0) ? 1 : 0);
                chk("fcount", 32'(frame_count), (e / TOT) % 65536);
            end
        end
    end

    // ------------------------------------------------------------- helpers
    // Step negedges until the selected sync reaches lvl; t counts the steps.
    task automatic run_until(input int which, input logic lvl, inout int t);
        int lim;
        lim = t + 2 * TOT * CLK_DIV;
        while (((which == 0) ? hsync : vsync) !== lvl && t < lim) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic hs_sched(inout int t);
        int t0;
        run_until(0, 1'b0, t);
        chk("hs_fall", t, CLK_DIV * (HA + HFP + 2));
        t0 = t;
        run_until(0, 1'b1, t);
        chk("hs_low", t - t0, CLK_DIV * HS);
        run_until(0, 1'b0, t);
        chk("hs_period", t - t0, CLK_DIV * HT);
    endtask

    task automatic pulse_rst(input string tag);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_rst(tag);   // mid-cycle: outputs must already be back at reset values
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int t, t0, fs, k;
        reset = 1'b0;
        box_x = '0;
        box_y = '0;
        lut[0] = 12'hFFF;   // blank code still returns a bright colour
        for (int i = 1; i < 8; i++) lut[i] = 12'($urandom);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);

        // Timing from release; frame 0 always uses the reset box (0,0).
        box_x = 10'd10;
        box_y = 10'd6;
        reset = 1'b0;
        t = 0;
        hs_sched(t);
        run_until(1, 1'b0, t);
        chk("vs_fall", t, CLK_DIV * ((VA + VFP) * HT + 2));
        t0 = t;
        run_until(1, 1'b1, t);
        chk("vs_low", t - t0, CLK_DIV * VS * HT);

        // Random box moves at arbitrary points inside frames.
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(200, 1400)) @(negedge clk);
            box_x = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, HA));
            box_y = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, VA));
        end

        // Box hanging off the bottom-right corner: clipped, border wins.
        box_x = 10'(HA - 4);
        box_y = 10'(VA - 3);
        repeat (2 * TOT * CLK_DIV) @(negedge clk);

        // Async reset in the middle of line 13, then identical hsync schedule.
        k = 0;
        while ((((n / CLK_DIV) % TOT) / HT) != 13 && k < TOT * CLK_DIV) begin
            @(negedge clk);
            k++;
        end
        repeat (CLK_DIV * HA / 2) @(negedge clk);
        pulse_rst("mid");
        t = 0;
        hs_sched(t);

        // Three whole frames from release: three pulses, count of 3.
        pulse_rst("rst2");
        fs = 0;
        for (int i = 0; i < 3 * TOT * CLK_DIV; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) fs++;
        end
        chk("frames", fs, 3);
        chk("fcount3", 32'(frame_count), 32'd3);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
